// File: rtl/parking_pkg.sv
// Shared types and widths for the parking-lot exit controller.
package parking_pkg;

   localparam int SLOT_W    = 2;
   localparam int NUM_SLOTS = 1 << SLOT_W;
   localparam int FEE_W     = 32;
   localparam int COIN_W    = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_REQ    = 3'd1,
      ST_FEE    = 3'd2,
      ST_PAY    = 3'd3,
      ST_GATE   = 3'd4,
      ST_REFUND = 3'd5
   } state_e;

endpackage

// File: rtl/exit_payment_ctrl_pay_timer.sv
// Loadable down-counter; done_o is high while the count sits at zero.
module pay_timer #(
   parameter int TMO_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [TMO_W-1:0] load_val_i,
   output logic             done_o
);

   logic [TMO_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)            cnt_d = load_val_i;
      else if (cnt_q != '0)  cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign done_o = (cnt_q == '0);

endmodule

// File: rtl/exit_payment_ctrl.sv
// Exit-side payment controller: fee request, coin collection, gate and change.
// Optional REVENUE_ACC_EN adds total_revenue / vehicle_count accumulators.
module exit_payment_ctrl
   import parking_pkg::*;
#(
   parameter int GATE_CYCLES = 50,
   parameter int PAY_TIMEOUT = 1000,
   parameter int TMO_W       = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 exit_req,
   input  logic [SLOT_W-1:0]    req_slot,
   input  logic [NUM_SLOTS-1:0] occupancy,
   input  logic [FEE_W-1:0]     fee,
   input  logic                 coin_valid,
   input  logic [COIN_W-1:0]    coin_value,
   input  logic                 cancel,
   output logic                 exit_pulse,
   output logic [SLOT_W-1:0]    exit_slot,
   output logic [FEE_W-1:0]     amount_due,
   output logic [FEE_W-1:0]     paid_sum,
   output logic [FEE_W-1:0]     change_out,
   output logic                 change_valid,
   output logic                 gate_open,
   output logic                 busy,
`ifdef REVENUE_ACC_EN
   output logic [FEE_W-1:0]     total_revenue,
   output logic [15:0]          vehicle_count,
`endif
   output logic                 error
);

   state_e              state_q, state_d;
   logic [SLOT_W-1:0]   exit_slot_q;
   logic [FEE_W-1:0]    amount_due_q, paid_sum_q, change_out_q;
   logic                change_valid_q, error_q;

   logic                coin_pay, tmr_done, tmo, gate_entry, tmr_load;
   logic [FEE_W-1:0]    paid_new, due_now;
   logic [TMO_W-1:0]    tmr_val;

   assign coin_pay   = (state_q == ST_PAY) && coin_valid;
   assign paid_new   = paid_sum_q + (coin_pay ? FEE_W'(coin_value) : '0);
   // Fee is being latched in the same edge when leaving FEE, so bypass it.
   assign due_now    = (state_q == ST_FEE) ? fee : amount_due_q;
   assign tmo        = (state_q == ST_PAY) && tmr_done && !coin_valid && !cancel;
   assign gate_entry = (state_d == ST_GATE) && (state_q != ST_GATE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (exit_req && occupancy[req_slot]) state_d = ST_REQ;
         ST_REQ:    state_d = ST_FEE;
         ST_FEE:    state_d = (fee == '0) ? ST_GATE : ST_PAY;
         ST_PAY: begin
            if (cancel || tmo)                  state_d = ST_REFUND;
            else if (paid_new >= amount_due_q)  state_d = ST_GATE;
         end
         ST_GATE:   if (tmr_done) state_d = ST_IDLE;
         ST_REFUND: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      exit_pulse = 1'b0;
      gate_open  = 1'b0;
      busy       = 1'b1;
      case (state_q)
         ST_IDLE: busy       = 1'b0;
         ST_REQ:  exit_pulse = 1'b1;
         ST_GATE: gate_open  = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exit_slot_q    <= '0;
         amount_due_q   <= '0;
         paid_sum_q     <= '0;
         change_out_q   <= '0;
         change_valid_q <= 1'b0;
         error_q        <= 1'b0;
      end else begin
         change_valid_q <= 1'b0;
         error_q        <= tmo;
         if (state_q == ST_IDLE && exit_req) begin
            if (occupancy[req_slot]) begin
               exit_slot_q <= req_slot;
               paid_sum_q  <= '0;
            end else begin
               error_q     <= 1'b1;
            end
         end
         if (state_q == ST_FEE) amount_due_q <= fee;
         if (state_q == ST_PAY) paid_sum_q   <= paid_new;
         if (gate_entry) begin
            change_out_q   <= paid_new - due_now;
            change_valid_q <= 1'b1;
         end
         if (state_d == ST_REFUND) begin
            change_out_q   <= paid_new;
            change_valid_q <= 1'b1;
         end
      end
   end

   // Timeout reloads on PAY entry and on every coin; gate hold loads on GATE entry.
   assign tmr_load = (state_q == ST_FEE) || gate_entry || coin_pay;
   assign tmr_val  = gate_entry ? TMO_W'(GATE_CYCLES - 1) : TMO_W'(PAY_TIMEOUT - 2);

   pay_timer #(.TMO_W(TMO_W)) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .done_o     (tmr_done)
   );

`ifdef REVENUE_ACC_EN
   logic [FEE_W-1:0] revenue_q;
   logic [15:0]      vcount_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         revenue_q <= '0;
         vcount_q  <= '0;
      end else if (gate_entry) begin
         revenue_q <= revenue_q + due_now;
         vcount_q  <= vcount_q + 16'd1;
      end
   end

   assign total_revenue = revenue_q;
   assign vehicle_count = vcount_q;
`endif

   assign exit_slot    = exit_slot_q;
   assign amount_due   = amount_due_q;
   assign paid_sum     = paid_sum_q;
   assign change_out   = change_out_q;
   assign change_valid = change_valid_q;
   assign error        = error_q;

endmodule

// File: tb/tb_exit_payment_ctrl.sv
// Bench for exit_payment_ctrl: directed table, corner sequences, random vs model.
module tb_exit_payment_ctrl;

   localparam int GC = 50;
   localparam int PT = 8;
   localparam int SLMAX = 32;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        exit_req = 1'b0;
   logic [1:0]  req_slot = '0;
   logic [3:0]  occupancy = '0;
   logic [31:0] fee = '0;
   logic        coin_valid = 1'b0;
   logic [7:0]  coin_value = '0;
   logic        cancel = 1'b0;
   logic        exit_pulse, change_valid, gate_open, busy, error;
   logic [1:0]  exit_slot;
   logic [31:0] amount_due, paid_sum, change_out;
`ifdef REVENUE_ACC_EN
   logic [31:0] total_revenue;
   logic [15:0] vehicle_count;
`endif

   exit_payment_ctrl #(.GATE_CYCLES(GC), .PAY_TIMEOUT(PT), .TMO_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .exit_req(exit_req), .req_slot(req_slot),
      .occupancy(occupancy), .fee(fee), .coin_valid(coin_valid),
      .coin_value(coin_value), .cancel(cancel), .exit_pulse(exit_pulse),
      .exit_slot(exit_slot), .amount_due(amount_due), .paid_sum(paid_sum),
      .change_out(change_out), .change_valid(change_valid),
      .gate_open(gate_open), .busy(busy),
`ifdef REVENUE_ACC_EN
      .total_revenue(total_revenue), .vehicle_count(vehicle_count),
`endif
      .error(error));

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Coin schedule, indexed by PAY cycle (k=0 is the first PAY cycle)
   int         sl;
   logic       sv   [SLMAX];
   logic       sc   [SLMAX];
   logic [7:0] sval [SLMAX];

   logic [31:0] m_amount = '0, m_paid = '0, m_rev = '0;
   int          m_vc = 0;

   typedef struct {
      int pulse, err, cv, gate, idle;
      logic [31:0] chg, amt, paid;
   } exp_t;

   typedef struct {
      int pn, pc, en, ec, cn, cc, gn, gf, lb;
      logic [31:0] cval;
      logic [1:0]  slot1;
   } obs_t;

   typedef struct {
      logic [3:0]      occ;
      logic [1:0]      slot;
      logic [31:0]     f;
      int              n;
      logic [2:0][7:0] coins;
      bit              cxl;
      bit              e_cv;
      logic [31:0]     e_chg;
      bit              e_gate;
      bit              e_err;
   } vec_t;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Walks the schedule by the payment rules; cycle numbers relative to the request cycle.
   task automatic model(input logic [3:0] occ, input logic [1:0] slot, input logic [31:0] f,
                        output exp_t e);
      logic [31:0] sum;
      int gap;
      bit cv, cx;
      e.pulse = -1; e.err = -1; e.cv = -1; e.gate = -1; e.idle = 0;
      e.chg = '0; e.amt = m_amount; e.paid = m_paid;
      if (!occ[slot]) begin
         e.err = 1;
         return;
      end
      e.pulse = 1; e.amt = f; sum = '0; gap = 0;
      if (f == '0) begin
         e.gate = 3; e.cv = 3; e.idle = 3 + GC;
      end else begin
         for (int k = 0; k < 4000; k++) begin
            cv = (k < sl) && sv[k];
            cx = (k < sl) && sc[k];
            if (cv) sum = sum + 32'(sval[k]);
            if (cx) begin
               e.cv = 4 + k; e.chg = sum; e.idle = 5 + k; break;
            end
            if (sum >= f) begin
               e.gate = 4 + k; e.cv = 4 + k; e.chg = sum - f; e.idle = 4 + k + GC; break;
            end
            gap = cv ? 0 : gap + 1;
            if (gap == PT - 1) begin
               e.err = 4 + k; e.cv = 4 + k; e.chg = sum; e.idle = 5 + k; break;
            end
         end
      end
      e.paid = sum;
   endtask

   task automatic run_txn(input string id, input logic [3:0] occ, input logic [1:0] slot,
                          input logic [31:0] f, input int xreq_in, output obs_t o);
      exp_t e;
      int last, k, xreq;
      model(occ, slot, f, e);
      xreq = xreq_in;
      if (xreq == -2) xreq = (e.idle > 2) ? $urandom_range(e.idle - 1, 1) : -1;
      o.pn = 0; o.pc = -1; o.en = 0; o.ec = -1; o.cn = 0; o.cc = -1;
      o.gn = 0; o.gf = -1; o.lb = -1; o.cval = '0; o.slot1 = '0;
      last = (e.idle > 0) ? e.idle + 1 : 3;
      for (int c = 0; c <= last; c++) begin
         @(negedge clk);
         if (exit_pulse)   begin o.pn++; o.pc = c; end
         if (error)        begin o.en++; o.ec = c; end
         if (change_valid) begin o.cn++; o.cc = c; o.cval = change_out; end
         if (gate_open)    begin o.gn++; if (o.gf < 0) o.gf = c; end
         if (busy) o.lb = c;
         if (c == 1) o.slot1 = exit_slot;
         exit_req   = (c == 0) || (c == xreq);
         req_slot   = (c == 0) ? slot : 2'($urandom);
         occupancy  = (c == 0) ? occ : 4'($urandom);
         fee        = (c == 2) ? f : $urandom;
         k          = c - 3;
         coin_valid = (k >= 0) && (k < sl) && sv[k];
         coin_value = (k >= 0 && k < sl) ? sval[k] : 8'($urandom);
         cancel     = (k >= 0) && (k < sl) && sc[k];
      end
      exit_req = 1'b0; coin_valid = 1'b0; cancel = 1'b0;
      chk({id, " pulse_cnt"}, o.pn, (e.pulse >= 0) ? 1 : 0);
      chk({id, " pulse_cyc"}, o.pc, e.pulse);
      chk({id, " err_cnt"},   o.en, (e.err >= 0) ? 1 : 0);
      chk({id, " err_cyc"},   o.ec, e.err);
      chk({id, " cv_cnt"},    o.cn, (e.cv >= 0) ? 1 : 0);
      chk({id, " cv_cyc"},    o.cc, e.cv);
      if (e.cv >= 0) chk({id, " change"}, o.cval, e.chg);
      chk({id, " gate_len"},  o.gn, (e.gate >= 0) ? GC : 0);
      chk({id, " gate_cyc"},  o.gf, e.gate);
      chk({id, " last_busy"}, o.lb, e.idle - 1);
      chk({id, " amount"},    amount_due, e.amt);
      chk({id, " paid"},      paid_sum, e.paid);
      if (e.pulse >= 0) chk({id, " exit_slot"}, o.slot1, slot);
      m_amount = e.amt; m_paid = e.paid;
      if (e.gate >= 0) begin m_rev = m_rev + e.amt; m_vc++; end
   endtask

   vec_t tbl[8];
   obs_t o;

   initial begin
      tbl[0] = '{4'b0001, 2'd0, 32'd50,  3, {8'd20, 8'd20, 8'd20}, 1'b0, 1'b1, 32'd10, 1'b1, 1'b0};
      tbl[1] = '{4'b0000, 2'd2, 32'd50,  0, {8'd0, 8'd0, 8'd0},    1'b0, 1'b0, 32'd0,  1'b0, 1'b1};
      tbl[2] = '{4'b1000, 2'd3, 32'd0,   0, {8'd0, 8'd0, 8'd0},    1'b0, 1'b1, 32'd0,  1'b1, 1'b0};
      tbl[3] = '{4'b0010, 2'd1, 32'd100, 2, {8'd0, 8'd10, 8'd40},  1'b1, 1'b1, 32'd50, 1'b0, 1'b0};
      tbl[4] = '{4'b0100, 2'd2, 32'd30,  1, {8'd0, 8'd0, 8'd10},   1'b0, 1'b1, 32'd10, 1'b0, 1'b1};
      tbl[5] = '{4'b1111, 2'd1, 32'd255, 1, {8'd0, 8'd0, 8'd255},  1'b0, 1'b1, 32'd0,  1'b1, 1'b0};
      tbl[6] = '{4'b0011, 2'd0, 32'd10,  2, {8'd0, 8'd5, 8'd5},    1'b1, 1'b1, 32'd10, 1'b0, 1'b0};
      tbl[7] = '{4'b0100, 2'd2, 32'd20,  1, {8'd0, 8'd0, 8'd25},   1'b0, 1'b1, 32'd5,  1'b1, 1'b0};

      repeat (3) @(negedge clk);
      chk("reset outputs", {exit_pulse, change_valid, gate_open, busy, error, exit_slot,
                            amount_due, paid_sum, change_out}, 0);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         sl = tbl[i].n;
         for (int k = 0; k < SLMAX; k++) begin
            sv[k] = (k < tbl[i].n); sc[k] = 1'b0;
            sval[k] = (k < tbl[i].n) ? tbl[i].coins[k] : 8'd0;
         end
         if (tbl[i].cxl) sc[tbl[i].n - 1] = 1'b1;
         run_txn($sformatf("vec%0d", i), tbl[i].occ, tbl[i].slot, tbl[i].f, -1, o);
         chk($sformatf("vec%0d tbl_cv", i), o.cn, tbl[i].e_cv);
         if (tbl[i].e_cv) chk($sformatf("vec%0d tbl_change", i), o.cval, tbl[i].e_chg);
         chk($sformatf("vec%0d tbl_gate", i), o.gn > 0, tbl[i].e_gate);
         chk($sformatf("vec%0d tbl_err", i), o.en > 0, tbl[i].e_err);
      end

      // Second request while the gate is open must be dropped.
      sl = 1; sv[0] = 1'b1; sc[0] = 1'b0; sval[0] = 8'd10;
      run_txn("gate_xreq", 4'b0001, 2'd0, 32'd5, 20, o);

      for (int t = 0; t < 40; t++) begin
         sl = SLMAX;
         for (int k = 0; k < SLMAX; k++) begin
            sv[k]   = 1'($urandom);
            sval[k] = 8'($urandom_range(120, 0));
            sc[k]   = ($urandom_range(24, 0) == 0);
         end
         run_txn($sformatf("rnd%0d", t), 4'($urandom), 2'($urandom),
                 ($urandom_range(5, 0) == 0) ? 32'd0 : 32'($urandom_range(300, 1)), -2, o);
      end

`ifdef REVENUE_ACC_EN
      chk("revenue", total_revenue, m_rev);
      chk("vehicles", vehicle_count, m_vc);
`endif

      // Asynchronous reset in the middle of PAY abandons the transaction.
      @(negedge clk); occupancy = 4'b0001; req_slot = 2'd0; exit_req = 1'b1;
      @(negedge clk); exit_req = 1'b0;
      @(negedge clk); fee = 32'd100;
      @(negedge clk); coin_valid = 1'b1; coin_value = 8'd30;
      @(negedge clk); coin_valid = 1'b0;
      chk("midpay busy", busy, 1);
      chk("midpay paid", paid_sum, 30);
      #2 rst_n = 1'b0;
      #1 chk("async reset outputs", {exit_pulse, change_valid, gate_open, busy, error,
                                     exit_slot, amount_due, paid_sum, change_out}, 0);
`ifdef REVENUE_ACC_EN
      chk("reset revenue", {total_revenue, vehicle_count}, 0);
`endif
      @(negedge clk); rst_n = 1'b1;
      m_amount = '0; m_paid = '0;
      begin
         int stray = 0;
         repeat (6) begin
            @(negedge clk);
            if (change_valid || busy || gate_open) stray++;
         end
         chk("post reset quiet", stray, 0);
      end

      sl = 2; sv[0] = 1'b1; sv[1] = 1'b1; sc[0] = 1'b0; sc[1] = 1'b0;
      sval[0] = 8'd7; sval[1] = 8'd9;
      run_txn("after_reset", 4'b0010, 2'd1, 32'd12, -1, o);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

endmodule
